pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core. It supersedes the fixed IF/ID latch and is reused at every stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB. It carries PC, instruction and a generic control bundle under a valid/ready handshake, with an optional skid entry so back-pressure never drops a beat. It also supports flush (bubble insertion) on taken branch/jump and counts bubbles delivered downstream.

## Interface
Parameters:
- CTRL_W, 12: width of the control bundle.
- CNT_W, 16: width of the bubble counter.
- NOP_INST, 32'h0000_0000: instruction word presented while the output is invalid.

Ports:
- clk  in  1  rising-edge clock; the single clock for the block.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  squash all held and incoming beats this cycle.
- in_valid_i  in  1  upstream beat present.
- in_ready_o  out  1  block can accept a beat this cycle.
- in_pc_i  in  32  PC of the incoming beat.
- in_inst_i  in  32  instruction of the incoming beat.
- in_ctrl_i  in  CTRL_W  decoded control bundle of the incoming beat.
- out_valid_o  out  1  held beat valid.
- out_ready_i  in  1  downstream accepts this cycle.
- out_pc_o  out  32  PC of the held beat.
- out_inst_o  out  32  instruction of the held beat.
- out_ctrl_o  out  CTRL_W  control bundle of the held beat.
- bubble_cnt_o  out  CNT_W  saturating count of bubbles consumed downstream.

## Operation
- A beat transfers on the input when in_valid_i & in_ready_o, and on the output when out_valid_o & out_ready_i.
- Storage is a main slot (drives the outputs) plus a skid slot.
- States:
  - EMPTY: main slot invalid.
  - FULL: main slot valid, skid slot invalid.
  - SKID: both slots valid.
- Transitions, with flush_i=0:
  - EMPTY + in accept -> FULL.
  - FULL + out accept, no in accept -> EMPTY.
  - FULL + in and out accept -> FULL; main slot loads the new beat.
  - FULL + in accept, no out accept -> SKID; the beat goes to the skid slot.
  - SKID + out accept -> FULL; main slot takes the skid contents.
  - In SKID the input never accepts.
- Beat order is always preserved.
- in_ready_o = !skid_valid. It is registered and has no combinational path from out_ready_i.
- Flush: at the next edge both slots are invalidated and the state becomes EMPTY. A beat offered in the same cycle is dropped, because flush wins over accept. out_valid_o is 0 on the following cycle.
- Invalid output: out_inst_o = NOP_INST and out_ctrl_o = 0, so downstream always sees a harmless bubble. out_pc_o holds its last value.
- Bubble counter: increments by 1 on each edge where out_valid_o=0 and out_ready_i=1. It saturates at 2^CNT_W-1 and does not wrap. It is cleared only by reset.
- Reset (asynchronous assert):
  - out_valid_o=0, out_pc_o=0, out_inst_o=NOP_INST, out_ctrl_o=0.
  - in_ready_o=1, bubble_cnt_o=0, state EMPTY.
  - Reset asserted mid-operation discards both slots immediately.

## Timing
- Latency: an accepted beat appears on the outputs 1 cycle later.
- Throughput: 1 beat per cycle while out_ready_i=1.
- in_ready_o falls 1 cycle after the first stalled accept, and rises 1 cycle after the skid slot drains.
- flush_i takes effect at the next edge. Nothing accepted in the flush cycle survives.
- Deassertion of rst_n is sampled at a clk edge; the first accept can occur on the first edge after release.

## Configuration
- Macro PIPE_STAGE_REG_SKID_EN, when defined: two-slot skid behaviour exactly as described above.
- When not defined:
  - Single slot only; the SKID state does not exist.
  - in_ready_o = out_ready_i | !out_valid_o, which is combinational.
  - All other behaviour (flush, bubbles, counter, reset values) is unchanged.

## Structure
- Shared package pipe_pkg holds:
  - the NOP_INST default constant;
  - the state enum {EMPTY, FULL, SKID};
  - the default CTRL_W and CNT_W values, shared by all four stage instances.
- Sub-module pipe_slot: one valid bit plus a PC/inst/ctrl payload register with load, clear and asynchronous reset. It is instantiated twice, or once when the skid macro is off.
- The state machine, handshake and bubble counter live in pipe_stage_reg.

## Test plan
- Reset: hold rst_n=0 mid-stream with both slots full, then release. Required: out_valid_o=0, out_inst_o=32'h0, in_ready_o=1, bubble_cnt_o=0.
- Streaming: send PCs 0x00, 0x04, 0x08, 0x0C back-to-back with out_ready_i=1. Required: the same PCs appear on out_pc_o 1 cycle later, with no gaps.
- Back-pressure: send 0x10 then 0x14, dropping out_ready_i in the cycle 0x14 is accepted. Required: in_ready_o=0 on the next cycle. After out_ready_i returns, 0x10 then 0x14 are delivered in order and in_ready_o=1.
- Flush: with the block in SKID and flush_i=1 while in_valid_i=1 (PC 0x20), the next cycle shows out_valid_o=0 and out_ctrl_o=0. PC 0x20 never appears.
- Bubble counter: 5 cycles of out_valid_o=0 with out_ready_i=1 give bubble_cnt_o=5. With CNT_W=2, 6 such cycles leave it at 3.
- Macro off: repeat the back-pressure case. Required: in_ready_o follows out_ready_i in the same cycle, and no beat is lost or duplicated.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: default widths, the
// NOP instruction word and the occupancy state encoding.
package pipe_pkg;

    localparam int          CTRL_W_DEF   = 12;
    localparam int          CNT_W_DEF    = 16;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline register: a valid bit plus PC/inst/ctrl payload.
// Clear wins over load; the payload is kept on clear so the PC output holds.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       inst_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       inst_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        ctrl_d  = ctrl_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            inst_d  = inst_i;
            ctrl_d  = ctrl_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and a saturating bubble counter.
// Define PIPE_STAGE_REG_SKID_EN for the two-slot skid version (registered in_ready_o).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          CTRL_W   = CTRL_W_DEF,
    parameter int          CNT_W    = CNT_W_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       in_pc_i,
    input  logic [31:0]       in_inst_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_pc_o,
    output logic [31:0]       out_inst_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    pipe_state_e       state_q, state_d;
    logic              main_valid, main_load, main_clr;
    logic [31:0]       main_pc, main_inst, main_pc_in, main_inst_in;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_in;
    logic              in_acc, out_acc;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign in_acc  = in_valid_i & in_ready_o;
    assign out_acc = main_valid & out_ready_i;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic              skid_valid, skid_load, skid_clr, main_from_skid;
    logic [31:0]       skid_pc, skid_inst;
    logic [CTRL_W-1:0] skid_ctrl;

    pipe_slot #(.CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clr_i   (skid_clr),
        .pc_i    (in_pc_i),
        .inst_i  (in_inst_i),
        .ctrl_i  (in_ctrl_i),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .inst_o  (skid_inst),
        .ctrl_o  (skid_ctrl)
    );

    // Ready depends only on the skid flop, so back-pressure is cut at this stage.
    assign in_ready_o   = !skid_valid;
    assign main_pc_in   = main_from_skid ? skid_pc   : in_pc_i;
    assign main_inst_in = main_from_skid ? skid_inst : in_inst_i;
    assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl_i;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        main_from_skid = 1'b0;
        if (flush_i) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
            state_d  = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_acc) begin
                    main_load = 1'b1;
                    state_d   = FULL;
                end
                FULL: if (in_acc && out_acc) begin
                    main_load = 1'b1;
                end else if (in_acc) begin
                    skid_load = 1'b1;
                    state_d   = SKID;
                end else if (out_acc) begin
                    main_clr = 1'b1;
                    state_d  = EMPTY;
                end
                SKID: if (out_acc) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clr       = 1'b1;
                    state_d        = FULL;
                end
                default: state_d = EMPTY;
            endcase
        end
    end
`else
    assign in_ready_o   = out_ready_i | !main_valid;
    assign main_pc_in   = in_pc_i;
    assign main_inst_in = in_inst_i;
    assign main_ctrl_in = in_ctrl_i;

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        if (flush_i) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
        end else if (in_acc) begin
            main_load = 1'b1;
            state_d   = FULL;
        end else if (out_acc) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
        end
    end
`endif

    pipe_slot #(.CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (main_load),
        .clr_i   (main_clr),
        .pc_i    (main_pc_in),
        .inst_i  (main_inst_in),
        .ctrl_i  (main_ctrl_in),
        .valid_o (main_valid),
        .pc_o    (main_pc),
        .inst_o  (main_inst),
        .ctrl_o  (main_ctrl)
    );

    // A bubble is counted when downstream is ready but we have nothing to give.
    always_comb begin
        cnt_d = cnt_q;
        if (!main_valid && out_ready_i) cnt_d = sat_inc(cnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid_o  = main_valid;
    assign out_pc_o     = main_pc;
    assign out_inst_o   = main_valid ? main_inst : NOP_INST;
    assign out_ctrl_o   = main_valid ? main_ctrl : '0;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed tables and sequences plus random traffic
// against a FIFO-occupancy reference model; works with or without the skid macro.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 12;
`ifdef PIPE_STAGE_REG_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush, in_valid, out_ready;
    logic [31:0]       in_pc, in_inst;
    logic [CTRL_W-1:0] in_ctrl;
    logic              in_ready, out_valid;
    logic [31:0]       out_pc, out_inst;
    logic [CTRL_W-1:0] out_ctrl;
    logic [15:0]       cnt;
    logic              in_ready2, out_valid2;
    logic [31:0]       out_pc2, out_inst2;
    logic [CTRL_W-1:0] out_ctrl2;
    logic [1:0]        cnt2;

    int checks = 0;
    int failures = 0;

    logic [31:0] q[$];
    logic [31:0] last_pc = 32'h0;
    int          m_cnt = 0;
    int          m_cnt2 = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0003;
    endfunction

    function automatic logic [CTRL_W-1:0] ctrl_of(input logic [31:0] pc);
        return {1'b1, pc[12:2]};
    endfunction

    assign in_inst = inst_of(in_pc);
    assign in_ctrl = ctrl_of(in_pc);

    pipe_stage_reg #(.CTRL_W(CTRL_W), .CNT_W(16), .NOP_INST(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_pc_i(in_pc), .in_inst_i(in_inst), .in_ctrl_i(in_ctrl), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_pc_o(out_pc), .out_inst_o(out_inst), .out_ctrl_o(out_ctrl),
        .bubble_cnt_o(cnt)
    );

    pipe_stage_reg #(.CTRL_W(CTRL_W), .CNT_W(2), .NOP_INST(32'h0000_0000)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .in_pc_i(in_pc), .in_inst_i(in_inst), .in_ctrl_i(in_ctrl), .out_valid_o(out_valid2),
        .out_ready_i(out_ready), .out_pc_o(out_pc2), .out_inst_o(out_inst2), .out_ctrl_o(out_ctrl2),
        .bubble_cnt_o(cnt2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready(input logic ordy);
        return (CAP == 2) ? (q.size() < 2) : (ordy || q.size() == 0);
    endfunction

    task automatic check_model();
        logic [31:0] e_inst;
        logic [CTRL_W-1:0] e_ctrl;
        e_inst = 32'h0;
        e_ctrl = '0;
        if (q.size() > 0) begin
            last_pc = q[0];
            e_inst  = inst_of(q[0]);
            e_ctrl  = ctrl_of(q[0]);
        end
        chk("out_valid", out_valid, q.size() > 0);
        chk("out_pc", out_pc, last_pc);
        chk("out_inst", out_inst, e_inst);
        chk("out_ctrl", out_ctrl, e_ctrl);
        chk("in_ready", in_ready, model_ready(out_ready));
        chk("bubble_cnt", cnt, m_cnt);
        chk("bubble_cnt_w2", cnt2, m_cnt2);
        chk("out_valid_w2", out_valid2, q.size() > 0);
        chk("in_ready_w2", in_ready2, model_ready(out_ready));
        chk("out_pc_w2", out_pc2, last_pc);
        chk("out_inst_w2", out_inst2, e_inst);
        chk("out_ctrl_w2", out_ctrl2, e_ctrl);
    endtask

    // Called at posedge+1: drive, then check at the falling edge.
    task automatic step(input logic fl, input logic iv, input logic [31:0] pc, input logic ordy);
        flush = fl;
        in_valid = iv;
        in_pc = pc;
        out_ready = ordy;
        #4;
        check_model();
    endtask

    task automatic tick();
        logic in_acc, out_acc;
        in_acc  = in_valid && model_ready(out_ready);
        out_acc = (q.size() > 0) && out_ready;
        if (q.size() == 0 && out_ready) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        if (flush) q.delete();
        else begin
            if (out_acc) void'(q.pop_front());
            if (in_acc) q.push_back(in_pc);
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        exp_ov;
        logic [31:0] exp_pc;
        logic        exp_ir;
    } vec_t;

    vec_t stream_tbl[5];

    initial begin
        flush = 0; in_valid = 0; in_pc = 0; out_ready = 0;
        stream_tbl[0] = '{1'b1, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1};
        stream_tbl[1] = '{1'b1, 32'h04, 1'b1, 1'b1, 32'h00, 1'b1};
        stream_tbl[2] = '{1'b1, 32'h08, 1'b1, 1'b1, 32'h04, 1'b1};
        stream_tbl[3] = '{1'b1, 32'h0C, 1'b1, 1'b1, 32'h08, 1'b1};
        stream_tbl[4] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h0C, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        step(0, 0, 0, 0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_cnt", cnt, 0);
        tick();

        // Bubble counter: six idle-but-ready cycles
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1);
            if (i == 5) chk("bubble_5", cnt, 5);
            tick();
        end
        step(0, 0, 0, 0);
        chk("bubble_sat_w2", cnt2, 3);
        chk("bubble_6", cnt, 6);
        tick();

        // Streaming table
        for (int i = 0; i < 5; i++) begin
            step(0, stream_tbl[i].iv, stream_tbl[i].pc, stream_tbl[i].ordy);
            chk($sformatf("stream%0d_valid", i), out_valid, stream_tbl[i].exp_ov);
            chk($sformatf("stream%0d_pc", i), out_pc, stream_tbl[i].exp_pc);
            chk($sformatf("stream%0d_ready", i), in_ready, stream_tbl[i].exp_ir);
            tick();
        end

        // Back-pressure
`ifdef PIPE_STAGE_REG_SKID_EN
        step(0, 1, 32'h10, 1); chk("bp_ready0", in_ready, 1); tick();
        step(0, 1, 32'h14, 0); chk("bp_ready1", in_ready, 1); chk("bp_pc1", out_pc, 32'h10); tick();
        step(0, 0, 0, 0);      chk("bp_ready_low", in_ready, 0); tick();
        step(0, 0, 0, 1);      chk("bp_first", out_pc, 32'h10); tick();
        step(0, 0, 0, 1);      chk("bp_second", out_pc, 32'h14); chk("bp_ready_back", in_ready, 1); tick();
`else
        step(0, 1, 32'h10, 1); chk("bp_ready0", in_ready, 1); tick();
        step(0, 1, 32'h14, 0); chk("bp_ready_comb_low", in_ready, 0); chk("bp_pc1", out_pc, 32'h10); tick();
        step(0, 1, 32'h14, 1); chk("bp_ready_comb_high", in_ready, 1); chk("bp_first", out_pc, 32'h10); tick();
        step(0, 0, 0, 1);      chk("bp_second", out_pc, 32'h14); tick();
`endif
        step(0, 0, 0, 1); chk("bp_drained", out_valid, 0); tick();

        // Flush while held beats (both slots in the skid build) and a new beat offered
        step(0, 1, 32'h18, 0); tick();
        step(0, 1, 32'h1C, 0); tick();
        step(1, 1, 32'h20, 0); tick();
        step(0, 0, 0, 1); chk("flush_valid", out_valid, 0); chk("flush_ctrl", out_ctrl, 0); tick();
        step(0, 0, 0, 1); chk("flush_no_20", out_valid, 0); tick();
        // Flush beats an accept that would otherwise succeed
        step(0, 1, 32'h30, 1); tick();
        step(1, 1, 32'h34, 1); chk("flush_acc_ready", in_ready, 1); tick();
        step(0, 0, 0, 1); chk("flush_drop_34", out_valid, 0); tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 16) == 0, ($urandom % 10) < 7, $urandom & 32'hFFFF_FFFC, ($urandom % 10) < 6);
            tick();
        end

        // Asynchronous reset mid-stream with storage full
        step(0, 1, 32'h40, 0); tick();
        step(0, 1, 32'h44, 0); tick();
        out_ready = 0; in_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_inst", out_inst, 32'h0);
        chk("arst_ready", in_ready, 1);
        chk("arst_cnt", cnt, 0);
        chk("arst_pc", out_pc, 0);
        q.delete(); m_cnt = 0; m_cnt2 = 0; last_pc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        step(0, 1, 32'h48, 1); tick();
        step(0, 0, 0, 1); chk("post_rst_pc", out_pc, 32'h48); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
